writeback_scheduler: RTL

//   Shares the single register-file write port between REQUESTERS functional units with a

---
 rtl/writeback_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/writeback_scheduler.sv
// Write-back scheduler: round-robin sharing of the single register-file
// write port between functional units, plus per-unit credit counters that
// raise an issue stall when the targeted unit has no free slot.
module writeback_scheduler #(
    parameter int REQUESTERS     = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int CREDITS        = 2
) (
    input  logic                                   clk,
    input  logic                                   async_rst_n,
    input  logic                                   clk_en,
    input  logic                                   IssueValid,
    input  logic [$clog2(REQUESTERS)-1:0]          IssueUnit,
    output logic                                   IssueCongestionStall,
    input  logic [REQUESTERS-1:0]                  WbReqValid,
    input  logic [REQUESTERS*REG_ADDR_WIDTH-1:0]   WbReqAddr,
    input  logic [REQUESTERS*DATA_WIDTH-1:0]       WbReqData,
    output logic [REQUESTERS-1:0]                  WbReqReady,
    output logic                                   RegWriteEn,
    output logic [REG_ADDR_WIDTH-1:0]              RegWriteAddr,
    output logic [DATA_WIDTH-1:0]                  RegWriteData,
    output logic                                   Busy
);

    localparam int UW = $clog2(REQUESTERS);
    localparam int CW = $clog2(CREDITS + 1);

    logic [CW-1:0]             r_cnt [REQUESTERS];
    logic [UW-1:0]             r_ptr;
    logic                      r_we;
    logic [REG_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]     r_data;

    logic                      w_unit_oob;
    logic [CW-1:0]             w_issue_cnt;
    logic                      w_stall;
    logic                      w_issue_accept;
    logic [REQUESTERS-1:0]     w_inc;
    logic [REQUESTERS-1:0]     w_grant;
    logic                      w_grant_any;
    logic [UW-1:0]             w_grant_idx;
    logic [UW:0]               w_sum;
    logic [UW-1:0]             w_idx;
    logic [REG_ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0]     w_sel_data;
    logic                      w_any_credit;
    logic [UW-1:0]             w_ptr_next;

    // Credit lookup for the issuing unit and the resulting stall/accept.
    // The unit index is matched in a loop so a non-power-of-two unit count
    // never reads past the counter array.
    always_comb begin
        w_unit_oob  = ({{(32-UW){1'b0}}, IssueUnit} >= 32'(REQUESTERS));
        w_issue_cnt = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (IssueUnit == UW'(i)) begin
                w_issue_cnt = r_cnt[i];
            end
        end
        // Pre-edge count only: a same-cycle writeback does not release the stall.
        w_stall        = IssueValid && (w_unit_oob || (w_issue_cnt == CW'(CREDITS)));
        w_issue_accept = clk_en && IssueValid && !w_stall;
        w_inc          = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            w_inc[i] = w_issue_accept && (IssueUnit == UW'(i));
        end
    end

    // Round-robin search starting at the pointer; grant is suppressed while
    // clk_en is low so no result is consumed in a frozen cycle.
    always_comb begin
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        w_idx       = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            w_sum = {1'b0, r_ptr} + (UW+1)'(k);
            if (w_sum >= (UW+1)'(REQUESTERS)) begin
                w_sum = w_sum - (UW+1)'(REQUESTERS);
            end
            w_idx = w_sum[UW-1:0];
            if (clk_en && !w_grant_any && WbReqValid[w_idx]) begin
                w_grant_any        = 1'b1;
                w_grant_idx        = w_idx;
                w_grant[w_idx]     = 1'b1;
            end
        end
    end

    // Mux the granted unit's address and data and compute the next pointer.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = WbReqAddr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                w_sel_data = WbReqData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (w_grant_idx == UW'(REQUESTERS - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_grant_idx + UW'(1);
        end
    end

    // Per-unit credit counters; simultaneous issue and writeback cancel,
    // a writeback against an empty counter saturates at zero.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            for (int i = 0; i < REQUESTERS; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (clk_en) begin
            for (int i = 0; i < REQUESTERS; i++) begin
                if (w_inc[i] && !w_grant[i]) begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end else if (w_grant[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - CW'(1);
                end
            end
        end
    end

    // Round-robin pointer moves just past the unit that won.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_ptr <= '0;
        end else if (clk_en && w_grant_any) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Registered write port; address/data hold when there is no grant so the
    // port only toggles on real writes.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (clk_en) begin
            r_we <= w_grant_any;
            if (w_grant_any) begin
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
            end
        end
    end

    // Busy covers any outstanding credit or a write still in the output stage.
    always_comb begin
        w_any_credit = 1'b0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (r_cnt[i] != '0) begin
                w_any_credit = 1'b1;
            end
        end
    end

    assign IssueCongestionStall = w_stall;
    assign WbReqReady           = w_grant;
    assign RegWriteEn           = r_we;
    assign RegWriteAddr         = r_addr;
    assign RegWriteData         = r_data;
    assign Busy                 = r_we || w_any_credit;

endmodule
